sha256_wsched: RTL and testbench
================================

# sha256_wsched

SHA-256 message-schedule generator. It sits directly upstream of `sha_256_processor` and feeds it. It accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready stream. It then emits the expanded schedule W[0..ROUNDS-1], one word per accepted transfer, so the compression core can run from a single streamed word per round instead of 16 parallel `w` ports.

## Interface
Parameters:
- `ROUNDS`, default 64: number of schedule words emitted per block. Legal range 16..64.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: synchronous abort. Discards the current block and returns to LOAD.
- `in_valid`, in, 1: `in_word` is valid.
- `in_ready`, out, 1: the block will accept a message word.
- `in_word`, in, 32: message word. Word 0 (most significant) arrives first.
- `out_valid`, out, 1: `out_word` holds W[`out_idx`].
- `out_ready`, in, 1: the consumer accepts `out_word`.
- `out_word`, out, 32: schedule word W[t].
- `out_idx`, out, 6: t.
- `out_last`, out, 1: high when `out_idx` == ROUNDS-1 and `out_valid` is high.
- `busy`, out, 1: high in EMIT state.

## Operation
- Storage is a 16-entry window `win[0..15]` of 32-bit registers, a 4-bit load counter `lcnt`, and a 6-bit emit counter `ecnt`.
- States:
  - LOAD: `in_ready`=1 and `out_valid`=0. Each accepted word (`in_valid & in_ready`) is written to `win[lcnt]`, then `lcnt` increments.
    - Acceptance with `lcnt`==15 moves to EMIT and clears `lcnt`.
  - EMIT: `in_ready`=0 and `out_valid`=1. `out_word`=`win[0]` and `out_idx`=`ecnt`.
    - On each accept (`out_valid & out_ready`), the window shifts down: `win[i]` <= `win[i+1]` for i=0..14.
    - `win[15]` <= σ1(`win[14]`) + `win[9]` + σ0(`win[1]`) + `win[0]`, mod 2^32. This is W[t+16], because `win[i]`=W[t+i].
    - `ecnt` increments on each accept. An accept with `ecnt`==ROUNDS-1 moves to LOAD and clears `ecnt`.
- Function definitions:
  - σ0(x) = rotr7 ^ rotr18 ^ shr3.
  - σ1(x) = rotr17 ^ rotr19 ^ shr10.
  - All additions are 32-bit with carry-out discarded.
- With `out_ready` low in EMIT, all outputs hold and the window is frozen.
- `flush` from any state moves to LOAD, clears `lcnt` and `ecnt`, and deasserts `out_valid` next cycle. Window contents are don't-care.
- `in_valid` in EMIT is ignored. No word is consumed.
- Simultaneous events:
  - `reset` and `flush` together: reset wins.
  - `flush` with an in-flight `in_valid` or `out_ready` transfer: flush wins and the transfer does not occur.

## Timing
- All outputs are driven from registers or from `win[0]`, `ecnt` and the state register. There is no combinational path from `in_valid`, `out_ready` or `flush` to any output.
- Reset values:
  - State LOAD: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0.
  - `out_word`=0 (window cleared), `out_idx`=0, `lcnt`=0.
- Load-to-emit latency: 16th word accepted at edge N, so `out_valid`=1 with W[0] visible from N+1.
- Throughput is 1 word/cycle in both directions. The minimum block period is 16+ROUNDS cycles, i.e. 80 for the default.
- Emit-to-load: last word accepted at edge M, so `in_ready`=1 from M+1.
- Mid-operation reset or flush discards the partial block. The next accepted word is stored as word 0.

## Configuration
- `SHA256_WSCHED_NONCE_EN`
  - Defined: adds input port `nonce`, 32 bits. During LOAD, the word accepted at `lcnt`==3 stores `nonce` instead of `in_word`. The `in_word` transfer still completes normally. This matches the bitcoin second-block layout, where word 3 is the nonce.
  - Undefined: port absent. All 16 words come from `in_word`.

## Test plan
- "abc" padded block (0x61626380, fourteen zero words, 0x00000018), `out_ready` tied high:
  - W0=0x61626380 and W16=0x61626380.
  - W17=0x000F0000.
  - 64 outputs; `out_last` only at idx 63; `in_ready` returns the cycle after.
- Random `out_ready` backpressure on the same block:
  - Output sequence is identical to the no-stall run.
  - `out_word` and `out_idx` are stable while stalled.
- `in_valid` gaps during load, then 16 words 0x00000001..0x00000010:
  - W0..W15 echo the inputs in order.
  - `out_valid` rises exactly one cycle after the 16th accept.
- `flush` asserted at emit idx 20:
  - `out_valid`=0 next cycle.
  - A new block loads, and its W0 equals the new word 0.
- `reset` asserted after 7 loaded words:
  - All outputs return to reset values.
  - A following full block produces the correct schedule.
- With `SHA256_WSCHED_NONCE_EN`, `nonce`=0xDEADBEEF and `in_word`=0 for all 16 words:
  - W3=0xDEADBEEF.
  - All other W0..W15 are 0.

Source files
------------

// File: rtl/sha256_wsched.sv
// SHA-256 message-schedule generator: loads 16 words, streams W[0..ROUNDS-1].
// Optional nonce substitution for word 3 under SHA256_WSCHED_NONCE_EN.
module sha256_wsched #(
   parameter int ROUNDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
`ifdef SHA256_WSCHED_NONCE_EN
   input  logic [31:0] nonce,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [5:0]  out_idx,
   output logic        out_last,
   output logic        busy
);

   localparam logic       LOAD = 1'b0;
   localparam logic       EMIT = 1'b1;
   localparam logic [5:0] LAST = 6'(ROUNDS - 1);

   logic        state_q, state_d;
   logic [3:0]  lcnt_q, lcnt_d;
   logic [5:0]  ecnt_q, ecnt_d;
   logic [31:0] win_q [16];
   logic [31:0] win_d [16];
   logic [31:0] ld_word;
   logic [31:0] nxt_w;
   logic        ld_acc;
   logic        em_acc;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

`ifdef SHA256_WSCHED_NONCE_EN
   assign ld_word = (lcnt_q == 4'd3) ? nonce : in_word;
`else
   assign ld_word = in_word;
`endif

   assign ld_acc = in_valid & (state_q == LOAD);
   assign em_acc = out_ready & (state_q == EMIT);

   // win[i] holds W[t+i], so this is W[t+16]
   assign nxt_w = sig1(win_q[14]) + win_q[9]
                + sig0(win_q[1]) + win_q[0];

   always_comb begin
      state_d = state_q;
      lcnt_d  = lcnt_q;
      ecnt_d  = ecnt_q;
      win_d   = win_q;
      if (flush) begin
         state_d = LOAD;
         lcnt_d  = '0;
         ecnt_d  = '0;
      end else if (ld_acc) begin
         win_d[lcnt_q] = ld_word;
         lcnt_d        = lcnt_q + 4'd1;
         if (lcnt_q == 4'd15) begin
            state_d = EMIT;
            lcnt_d  = '0;
         end
      end else if (em_acc) begin
         for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
         end
         win_d[15] = nxt_w;
         ecnt_d    = ecnt_q + 6'd1;
         if (ecnt_q == LAST) begin
            state_d = LOAD;
            ecnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         lcnt_q  <= '0;
         ecnt_q  <= '0;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         lcnt_q  <= lcnt_d;
         ecnt_q  <= ecnt_d;
         win_q   <= win_d;
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == EMIT);
   assign busy      = (state_q == EMIT);
   assign out_word  = win_q[0];
   assign out_idx   = ecnt_q;
   assign out_last  = (state_q == EMIT) && (ecnt_q == LAST);

endmodule

// File: tb/tb_sha256_wsched.sv
// Self-checking bench for sha256_wsched against an array-based schedule model.
// Nonce test is compiled only with SHA256_WSCHED_NONCE_EN.
module tb_sha256_wsched;

   localparam int R = 64;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid, out_last, busy;
   logic [31:0] in_word, out_word, nonce_v;
   logic [5:0]  out_idx;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] blk [16];
   logic [31:0] W   [R];
   logic [31:0] got [R];
   int          last_cnt;

   always #5 clk = ~clk;

   sha256_wsched #(.ROUNDS(R)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
`ifdef SHA256_WSCHED_NONCE_EN
      .nonce(nonce_v),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_word(out_word), .out_idx(out_idx),
      .out_last(out_last), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Schedule recurrence straight from the SHA-256 definition
   task automatic model();
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) W[t] = blk[t];
`ifdef SHA256_WSCHED_NONCE_EN
      W[3] = nonce_v;
`endif
      for (int t = 16; t < R; t++) begin
         s0 = rotr(W[t-15], 7) ^ rotr(W[t-15], 18) ^ (W[t-15] >> 3);
         s1 = rotr(W[t-2], 17) ^ rotr(W[t-2], 19) ^ (W[t-2] >> 10);
         W[t] = s1 + W[t-7] + s0 + W[t-16];
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".out_last"},  32'(out_last),  32'd0);
      chk({tag, ".busy"},      32'(busy),      32'd0);
      chk({tag, ".out_word"},  out_word,       32'd0);
      chk({tag, ".out_idx"},   32'(out_idx),   32'd0);
   endtask

   task automatic load_words(input int n, input int gap);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 2000) begin
         @(negedge clk);
         chk("load.in_ready",  32'(in_ready),  32'd1);
         chk("load.out_valid", 32'(out_valid), 32'd0);
         in_valid = ($urandom_range(99) >= gap);
         in_word  = in_valid ? blk[i] : $urandom;
         if (in_valid) i++;
         guard++;
      end
      if (i < n) chk("load.timeout", 32'(i), 32'(n));
   endtask

   task automatic emit(input int stall, input int flush_at);
      int t = 0;
      int guard = 0;
      last_cnt = 0;
      while (t < R && guard < 5000) begin
         @(negedge clk);
         chk("emit.out_valid", 32'(out_valid), 32'd1);
         chk("emit.in_ready",  32'(in_ready),  32'd0);
         chk("emit.busy",      32'(busy),      32'd1);
         chk("emit.out_idx",   32'(out_idx),   32'(t));
         chk("emit.out_word",  out_word,       W[t]);
         chk("emit.out_last",  32'(out_last),  32'(t == R - 1));
         in_valid = $urandom_range(1);
         in_word  = $urandom;
         if (t == flush_at) begin
            flush     = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            flush     = 1'b0;
            out_ready = 1'b0;
            in_valid  = 1'b0;
            chk("flush.out_valid", 32'(out_valid), 32'd0);
            chk("flush.in_ready",  32'(in_ready),  32'd1);
            chk("flush.out_idx",   32'(out_idx),   32'd0);
            return;
         end
         out_ready = ($urandom_range(99) >= stall);
         if (out_ready) begin
            got[t] = out_word;
            if (out_last) last_cnt++;
            t++;
         end
         guard++;
      end
      if (t < R) chk("emit.timeout", 32'(t), 32'(R));
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("done.in_ready",  32'(in_ready),  32'd1);
      chk("done.out_valid", 32'(out_valid), 32'd0);
      chk("done.out_last",  32'(out_last),  32'd0);
      chk("done.last_cnt",  32'(last_cnt),  32'd1);
   endtask

   task automatic abc_block();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      model();
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; in_word = '0; nonce_v = $urandom;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;

      abc_block();
      load_words(16, 0);
      emit(0, -1);
`ifndef SHA256_WSCHED_NONCE_EN
      chk("abc.W0",  got[0],  32'h61626380);
      chk("abc.W16", got[16], 32'h61626380);
      chk("abc.W17", got[17], 32'h000F0000);
`endif

      abc_block();
      load_words(16, 0);
      emit(50, -1);
      for (int i = 0; i < R; i++) chk("stall.W", got[i], W[i]);

      for (int i = 0; i < 16; i++) blk[i] = 32'(i + 1);
      model();
      load_words(16, 60);
      emit(30, -1);

      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      model();
      load_words(16, 20);
      emit(0, 20);
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      model();
      load_words(16, 0);
      emit(20, -1);
      chk("flush.newW0", got[0], W[0]);

      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      load_words(7, 0);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b1; in_word = $urandom;
      @(negedge clk);
      in_valid = 1'b0;
      chk_reset_vals("midrst");
      reset = 1'b0;
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      model();
      load_words(16, 25);
      emit(25, -1);

`ifdef SHA256_WSCHED_NONCE_EN
      nonce_v = 32'hDEADBEEF;
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      model();
      load_words(16, 0);
      emit(0, -1);
      for (int i = 0; i < 16; i++)
         chk("nonce.W", got[i], (i == 3) ? 32'hDEADBEEF : 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
